// File: rtl/tennis_speed_pkg.sv
// tennis_speed_pkg: shared types and widths for the ball speed scheduler.
package tennis_speed_pkg;
  localparam int DIV_W = 27;
  localparam logic [3:0] LEVEL_MAX = 4'd15;
  typedef enum logic [1:0] {IDLE = 2'd0, RALLY = 2'd1, PAUSE = 2'd2} state_t;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector with async active-high reset.
module rise_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= d;
  assign rise = d & ~prev;
endmodule

// File: rtl/ball_speed_scheduler.sv
// ball_speed_scheduler: sequences serve/rally/pause and reprograms the clock divider on safe edges.
// SPEED_RAMP_EN: when defined, the divider period shrinks with speed_level; otherwise it stays at BASE_TOGGLE.
module ball_speed_scheduler
  import tennis_speed_pkg::*;
#(
  parameter logic [DIV_W-1:0] BASE_TOGGLE = 27'd2_500_000,
  parameter logic [DIV_W-1:0] STEP        = 27'd200_000,
  parameter logic [DIV_W-1:0] MIN_TOGGLE  = 27'd500_000,
  parameter logic [7:0]       PAUSE_TICKS = 8'd50
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             serve_req,
  input  logic             hit,
  input  logic             point,
  input  logic             divided_clk,
  output logic [DIV_W-1:0] toggle_value,
  output logic             div_rst,
  output logic [3:0]       speed_level,
  output logic [1:0]       state,
  output logic             busy
);
  state_t st;
  logic [7:0] ticks;
  logic rise;
  logic [DIV_W-1:0] target;
  rise_detect u_rise (.clk_in(clk_in), .rst(rst), .d(divided_clk), .rise(rise));
`ifdef SPEED_RAMP_EN
  // Signed so a large level underflows below the floor instead of wrapping.
  logic signed [31:0] raw;
  assign raw = $signed({5'd0, BASE_TOGGLE}) - $signed({28'd0, speed_level}) * $signed({5'd0, STEP});
  assign target = (raw < $signed({5'd0, MIN_TOGGLE})) ? MIN_TOGGLE : raw[DIV_W-1:0];
`else
  assign target = BASE_TOGGLE;
`endif
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      st           <= IDLE;
      toggle_value <= BASE_TOGGLE;
      div_rst      <= 1'b1;
      speed_level  <= '0;
      ticks        <= '0;
      busy         <= 1'b0;
    end else begin
      if (rise) toggle_value <= target;
      case (st)
        IDLE:
          if (serve_req) begin
            st      <= RALLY;
            div_rst <= 1'b0;
            busy    <= 1'b1;
          end
        RALLY:
          if (point) begin
            st          <= PAUSE;
            speed_level <= '0;
          end else if (hit && speed_level != LEVEL_MAX) speed_level <= speed_level + 4'd1;
        PAUSE:
          // Divider is held in reset on IDLE entry, so the base value can land at once.
          if (ticks == PAUSE_TICKS) begin
            st           <= IDLE;
            ticks        <= '0;
            div_rst      <= 1'b1;
            busy         <= 1'b0;
            toggle_value <= BASE_TOGGLE;
          end else if (rise) ticks <= ticks + 8'd1;
        default: begin
          st      <= IDLE;
          div_rst <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  assign state = st;
endmodule
